// File: rtl/m_assert_bank_if.sv
// Signal bundle between a design under observation and the assertion bank:
// violation inputs and controls travel one way, sticky status the other.
interface m_assert_bank_if #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 16,
  parameter int TS_W  = 32,
  parameter int ID_W  = (N_CH > 1) ? $clog2(N_CH) : 1
);

  logic [N_CH-1:0]  en;
  logic [N_CH-1:0]  expr;
  logic             clr;
  logic             armed;
  logic [N_CH-1:0]  fail_vec;
  logic             any_fail;
  logic             first_valid;
  logic [ID_W-1:0]  first_id;
  logic [TS_W-1:0]  first_ts;
  logic [CNT_W-1:0] fail_count;

  modport master (
    output en,
    output expr,
    output clr,
    input  armed,
    input  fail_vec,
    input  any_fail,
    input  first_valid,
    input  first_id,
    input  first_ts,
    input  fail_count
  );

  modport slave (
    input  en,
    input  expr,
    input  clr,
    output armed,
    output fail_vec,
    output any_fail,
    output first_valid,
    output first_id,
    output first_ts,
    output fail_count
  );

endinterface

// File: rtl/m_assert_bank.sv
// Multi-channel assertion bank: a channel fires once per violation episode
// that lasts HOLD armed samples; firings are latched, stamped and counted.
module m_assert_bank #(
  parameter int N_CH      = 4,
  parameter int HOLD      = 1,
  parameter int ARM_DELAY = 0,
  parameter int FATAL     = 1,
  parameter int CNT_W     = 16,
  parameter int TS_W      = 32,
  parameter     MESSAGE   = "[ASSERT]"
) (
  input  logic           clk,
  input  logic           rst,
  m_assert_bank_if.slave bus
);

  localparam int ID_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int RUN_W = (HOLD > 0) ? $clog2(HOLD + 1) : 1;
  localparam int ARM_W = (ARM_DELAY > 1) ? $clog2(ARM_DELAY + 1) : 1;
  localparam int PC_W  = $clog2(N_CH + 1);
  localparam int SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;

  localparam logic [RUN_W-1:0] RUN_FIRE = RUN_W'(HOLD - 1);
  localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(HOLD);
  localparam logic [ARM_W-1:0] ARM_LOAD = ARM_W'(ARM_DELAY);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic [TS_W-1:0]              ts_q, ts_d;
  logic [ARM_W-1:0]             armCnt_q, armCnt_d;
  logic                         armed_q, armed_d;
  logic [N_CH-1:0][RUN_W-1:0]   run_q, run_d;
  logic [N_CH-1:0]              fire;
  logic [PC_W-1:0]              firePop;
  logic [ID_W-1:0]              fireLow;

  logic [N_CH-1:0]              failVec_q, failVec_d;
  logic                         anyFail_q, anyFail_d;
  logic                         firstValid_q, firstValid_d;
  logic [ID_W-1:0]              firstId_q, firstId_d;
  logic [TS_W-1:0]              firstTs_q, firstTs_d;
  logic [CNT_W-1:0]             failCount_q, failCount_d;
  logic [CNT_W-1:0]             cntBase;
  logic [SUM_W-1:0]             cntSum;

  always_comb begin
    ts_d = (&ts_q) ? ts_q : ts_q + TS_W'(1);
  end

  // The arm counter holds the number of edges still to wait; the last one
  // raises armed, so ARM_DELAY of 0 and 1 both arm on the first edge.
  always_comb begin
    armCnt_d = armCnt_q;
    armed_d  = armed_q;
    if (!armed_q) begin
      if (armCnt_q <= ARM_W'(1)) begin
        armed_d = 1'b1;
      end else begin
        armCnt_d = armCnt_q - ARM_W'(1);
      end
    end
  end

  // Run counters saturate at HOLD so a held violation fires exactly once.
  always_comb begin
    run_d = run_q;
    fire  = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (armed_q && bus.en[i] && bus.expr[i]) begin
        fire[i] = (run_q[i] == RUN_FIRE);
        if (run_q[i] != RUN_MAX) begin
          run_d[i] = run_q[i] + RUN_W'(1);
        end
      end else begin
        run_d[i] = '0;
      end
    end
  end

  always_comb begin
    firePop = '0;
    fireLow = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      firePop = firePop + PC_W'(fire[i]);
      if (fire[i]) begin
        fireLow = ID_W'(i);
      end
    end
  end

  // Clear is applied first and firing on top of it, so a collision keeps
  // the new firing as the fresh first capture.
  always_comb begin
    failVec_d    = bus.clr ? '0 : failVec_q;
    firstValid_d = bus.clr ? 1'b0 : firstValid_q;
    firstId_d    = bus.clr ? '0 : firstId_q;
    firstTs_d    = bus.clr ? '0 : firstTs_q;
    cntBase      = bus.clr ? '0 : failCount_q;

    failVec_d = failVec_d | fire;
    cntSum    = SUM_W'(cntBase) + SUM_W'(firePop);
    if (cntSum > SUM_W'(CNT_MAX)) begin
      failCount_d = CNT_MAX;
    end else begin
      failCount_d = cntSum[CNT_W-1:0];
    end

    if ((|fire) && !firstValid_d) begin
      firstValid_d = 1'b1;
      firstId_d    = fireLow;
      firstTs_d    = ts_q;
    end

    anyFail_d = |failVec_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ts_q         <= '0;
      armCnt_q     <= ARM_LOAD;
      armed_q      <= 1'b0;
      run_q        <= '0;
      failVec_q    <= '0;
      anyFail_q    <= 1'b0;
      firstValid_q <= 1'b0;
      firstId_q    <= '0;
      firstTs_q    <= '0;
      failCount_q  <= '0;
    end else begin
      ts_q         <= ts_d;
      armCnt_q     <= armCnt_d;
      armed_q      <= armed_d;
      run_q        <= run_d;
      failVec_q    <= failVec_d;
      anyFail_q    <= anyFail_d;
      firstValid_q <= firstValid_d;
      firstId_q    <= firstId_d;
      firstTs_q    <= firstTs_d;
      failCount_q  <= failCount_d;
    end
  end

  assign bus.armed       = armed_q;
  assign bus.fail_vec    = failVec_q;
  assign bus.any_fail    = anyFail_q;
  assign bus.first_valid = firstValid_q;
  assign bus.first_id    = firstId_q;
  assign bus.first_ts    = firstTs_q;
  assign bus.fail_count  = failCount_q;

`ifndef SYNTHESIS
  // Logging reads the pre-edge fire vector and timestamp; all lines of an
  // edge are printed before the optional stop.
  always @(posedge clk) begin
    if (!rst && (|fire)) begin
      for (int i = 0; i < N_CH; i++) begin
        if (fire[i]) begin
          $display("%s ch=%0d t=%0d", MESSAGE, i, ts_q);
        end
      end
      if (FATAL != 0) begin
        $finish;
      end
    end
  end
`endif

endmodule

// File: tb/tb_m_assert_bank.sv
// Scoreboard bench for m_assert_bank: a streak-based reference model queues
// the expected status after every edge, and a monitor compares it.
module tb_m_assert_bank;

  localparam int N_CH      = 4;
  localparam int HOLD      = 3;
  localparam int ARM_DELAY = 5;
  localparam int CNT_W     = 3;
  localparam int TS_W      = 32;
  localparam int ID_W      = 2;
  localparam int CNT_MAX   = (1 << CNT_W) - 1;
  localparam longint TS_MAX = (64'd1 << TS_W) - 1;

  typedef struct {
    logic             armed;
    logic [N_CH-1:0]  failVec;
    logic             anyFail;
    logic             firstValid;
    logic [ID_W-1:0]  firstId;
    logic [TS_W-1:0]  firstTs;
    logic [CNT_W-1:0] failCount;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  m_assert_bank_if #(.N_CH(N_CH), .CNT_W(CNT_W), .TS_W(TS_W)) bus ();

  m_assert_bank #(
    .N_CH(N_CH), .HOLD(HOLD), .ARM_DELAY(ARM_DELAY), .FATAL(0),
    .CNT_W(CNT_W), .TS_W(TS_W), .MESSAGE("[ASSERT]")
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  exp_t expQ[$];
  int vectors = 0;
  int miscompares = 0;

  int              sinceReset = 0;
  bit              mArmed = 0;
  int              streak[N_CH];
  logic [N_CH-1:0] mFailVec = '0;
  int              mCount = 0;
  bit              mFirstValid = 0;
  int              mFirstId = 0;
  longint          mFirstTs = 0;
  longint          mTs = 0;

  // Reference model: a channel fires when its run of armed, enabled
  // violation samples reaches exactly HOLD.
  task automatic modelStep(input logic r, input logic [N_CH-1:0] e,
                           input logic [N_CH-1:0] x, input logic c);
    exp_t ex;
    logic [N_CH-1:0] fire;
    int pop;
    longint tsNow;
    if (r) begin
      sinceReset = 0; mArmed = 0; mFailVec = '0; mCount = 0;
      mFirstValid = 0; mFirstId = 0; mFirstTs = 0; mTs = 0;
      for (int i = 0; i < N_CH; i++) streak[i] = 0;
    end else begin
      fire = '0;
      pop = 0;
      for (int i = 0; i < N_CH; i++) begin
        if (mArmed && e[i] && x[i]) streak[i]++;
        else streak[i] = 0;
        if (streak[i] == HOLD) begin
          fire[i] = 1'b1;
          pop++;
        end
      end
      tsNow = mTs;
      if (c) begin
        mFailVec = '0; mCount = 0; mFirstValid = 0; mFirstId = 0; mFirstTs = 0;
      end
      mFailVec = mFailVec | fire;
      mCount = (mCount + pop > CNT_MAX) ? CNT_MAX : mCount + pop;
      for (int i = 0; i < N_CH; i++) begin
        if (fire[i] && !mFirstValid) begin
          mFirstValid = 1; mFirstId = i; mFirstTs = tsNow;
        end
      end
      mTs = (mTs == TS_MAX) ? mTs : mTs + 1;
      sinceReset++;
      mArmed = (sinceReset >= ((ARM_DELAY > 1) ? ARM_DELAY : 1));
    end
    ex.armed      = mArmed;
    ex.failVec    = mFailVec;
    ex.anyFail    = (mFailVec != 0);
    ex.firstValid = mFirstValid;
    ex.firstId    = ID_W'(mFirstId);
    ex.firstTs    = mFirstTs[TS_W-1:0];
    ex.failCount  = CNT_W'(mCount);
    expQ.push_back(ex);
  endtask

  task automatic applyStimulus(input logic r, input logic [N_CH-1:0] e,
                               input logic [N_CH-1:0] x, input logic c);
    @(negedge clk);
    rst      = r;
    bus.en   = e;
    bus.expr = x;
    bus.clr  = c;
    modelStep(r, e, x, c);
  endtask

  task automatic checkOutput(input exp_t ex);
    bit bad = 0;
    vectors++;
    if (bus.armed !== ex.armed) begin
      bad = 1; $display("[TB] FAIL armed vec=%0d got=%0b exp=%0b", vectors, bus.armed, ex.armed);
    end
    if (bus.fail_vec !== ex.failVec) begin
      bad = 1; $display("[TB] FAIL fail_vec vec=%0d got=%b exp=%b", vectors, bus.fail_vec, ex.failVec);
    end
    if (bus.any_fail !== ex.anyFail) begin
      bad = 1; $display("[TB] FAIL any_fail vec=%0d got=%0b exp=%0b", vectors, bus.any_fail, ex.anyFail);
    end
    if (bus.first_valid !== ex.firstValid) begin
      bad = 1; $display("[TB] FAIL first_valid vec=%0d got=%0b exp=%0b", vectors, bus.first_valid, ex.firstValid);
    end
    if (bus.first_id !== ex.firstId) begin
      bad = 1; $display("[TB] FAIL first_id vec=%0d got=%0d exp=%0d", vectors, bus.first_id, ex.firstId);
    end
    if (bus.first_ts !== ex.firstTs) begin
      bad = 1; $display("[TB] FAIL first_ts vec=%0d got=%0d exp=%0d", vectors, bus.first_ts, ex.firstTs);
    end
    if (bus.fail_count !== ex.failCount) begin
      bad = 1; $display("[TB] FAIL fail_count vec=%0d got=%0d exp=%0d", vectors, bus.fail_count, ex.failCount);
    end
    if (bad) miscompares++;
  endtask

  // Monitor: the DUT presents fresh status after every edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) checkOutput(expQ.pop_front());
    end
  end

  initial begin
    logic [N_CH-1:0] rx, re;
    logic rc, rr;
    bus.en = '0; bus.expr = '0; bus.clr = 1'b0;
    for (int i = 0; i < N_CH; i++) streak[i] = 0;

    repeat (2) applyStimulus(1, 4'hF, 4'h0, 0);
    // Arming delay with ch0 held from reset release.
    repeat (10) applyStimulus(0, 4'hF, 4'b0001, 0);
    applyStimulus(0, 4'hF, 4'h0, 0);
    // ch1: short burst then a firing burst.
    repeat (2) applyStimulus(0, 4'hF, 4'b0010, 0);
    applyStimulus(0, 4'hF, 4'h0, 0);
    repeat (3) applyStimulus(0, 4'hF, 4'b0010, 0);
    applyStimulus(0, 4'hF, 4'h0, 0);
    // Simultaneous ch3/ch2.
    repeat (3) applyStimulus(0, 4'hF, 4'b1100, 0);
    applyStimulus(0, 4'hF, 4'h0, 0);
    // Drive the counter into saturation.
    for (int k = 0; k < 6; k++) begin
      repeat (3) applyStimulus(0, 4'hF, 4'b0001, 0);
      applyStimulus(0, 4'hF, 4'h0, 0);
    end
    // Clear colliding with a ch0 firing, then a plain clear.
    repeat (2) applyStimulus(0, 4'hF, 4'b0001, 0);
    applyStimulus(0, 4'hF, 4'b0001, 1);
    applyStimulus(0, 4'hF, 4'h0, 0);
    applyStimulus(0, 4'hF, 4'h0, 1);
    // Masked channel, then unmasked mid-violation.
    repeat (5) applyStimulus(0, 4'b1110, 4'b0001, 0);
    repeat (4) applyStimulus(0, 4'hF, 4'b0001, 0);
    applyStimulus(0, 4'hF, 4'h0, 0);
    // Reset in the middle of an episode.
    repeat (2) applyStimulus(0, 4'hF, 4'b0010, 0);
    applyStimulus(1, 4'hF, 4'b0010, 0);
    repeat (9) applyStimulus(0, 4'hF, 4'b0010, 0);
    applyStimulus(0, 4'hF, 4'h0, 0);

    rx = '0;
    for (int k = 0; k < 600; k++) begin
      for (int i = 0; i < N_CH; i++) begin
        if ($urandom_range(0, 3) == 0) rx[i] = ~rx[i];
        re[i] = ($urandom_range(0, 7) != 0);
      end
      rc = ($urandom_range(0, 29) == 0);
      rr = ($urandom_range(0, 149) == 0);
      applyStimulus(rr, re, rx, rc);
    end

    for (int k = 0; k < 5 && expQ.size() > 0; k++) @(posedge clk);
    #2;
    if (expQ.size() > 0) begin
      $display("[TB] FAIL drain pending=%0d exp=0", expQ.size());
      miscompares++;
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/m_assert_bank.md
# m_assert_bank

Parametrised multi-channel assertion checker for simulation benches and debug builds. It watches N_CH independent violation expressions. A channel fires only after its expression has held for HOLD consecutive cycles, and checking starts only after an arming delay that follows reset. Each firing sets sticky per-channel flags, captures the first failing channel and its cycle stamp, and counts failures. Depending on FATAL, it then either ends simulation or logs and continues. It sits beside the datapath blocks (e.g. linked-list controller) and replaces ad-hoc single-expression checkers.

## Interface
- N_CH, 4, number of assertion channels (≥1)
- HOLD, 1, consecutive high samples required to fire (≥1)
- ARM_DELAY, 0, cycles after reset release during which checking is disabled
- FATAL, 1, 1: $finish at the end of the first cycle with a firing; 0: log only
- CNT_W, 16, width of fail_count
- TS_W, 32, width of the cycle timestamp
- MESSAGE, "[ASSERT]", string prefix for every log line
- clk  in  1  clock; all activity on rising edge
- rst  in  1  synchronous, active-high reset
- en  in  N_CH  per-channel enable mask
- expr  in  N_CH  per-channel violation expression (1 = violation)
- clr  in  1  clears sticky status (fail_vec, first_*, fail_count)
- armed  out  1  checking active
- fail_vec  out  N_CH  sticky per-channel fired flags
- any_fail  out  1  OR of fail_vec (registered)
- first_valid  out  1  first_id/first_ts hold a capture
- first_id  out  max(1,$clog2(N_CH))  index of first channel to fire
- first_ts  out  TS_W  timestamp of first firing
- fail_count  out  CNT_W  total firings, saturating at all-ones

## Operation
- Timestamp counter ts: 0 on the edge where rst is sampled high; +1 per cycle after that; saturates at all-ones.
- Arm counter: loaded on reset. armed goes 1 on the edge ending the ARM_DELAY-th post-reset cycle; with ARM_DELAY=0, armed=1 on the first post-reset edge.
- Per-channel run counter run[i], width $clog2(HOLD+1):
  - cleared when rst, !armed, !en[i] or !expr[i];
  - otherwise increments, saturating at HOLD.
- fire[i] = armed & en[i] & expr[i] & (run[i] == HOLD-1).
  - fire[i] pulses exactly once per continuous violation episode.
  - Re-firing requires expr[i] or en[i] to drop for at least one sample.
- On an edge with any fire[i]:
  - fail_vec[i] set for each fired channel.
  - fail_count += popcount(fire), saturating.
  - If !first_valid: first_id = lowest fired index, first_ts = current ts, first_valid = 1.
  - Display one line per fired channel: "%s ch=%0d t=%0d" (MESSAGE, index, ts).
  - If FATAL=1: after all lines for that edge are displayed, call $finish.
- clr: clears fail_vec, any_fail, first_valid, first_id, first_ts and fail_count.
  - Does not affect run counters, ts or armed.
  - Firing on the same edge as clr wins: state equals clear-then-apply-fire, so fail_count = popcount(fire) and first_* captures it.
- Reset mid-operation: all state returns to reset values. Arming restarts, and an in-progress violation episode is discarded.
- Logging and $finish use non-synthesisable constructs, guarded for simulation only. All registered outputs are synthesisable.

## Timing
- Reset values: armed=0 (or 1 one edge after reset if ARM_DELAY=0), fail_vec=0, any_fail=0, first_valid=0, first_id=0, first_ts=0, fail_count=0.
- Latency: expr[i] sampled high at armed edges k-HOLD+1 … k → fire at edge k, outputs visible after edge k. HOLD=1 means same-edge detection.
- any_fail updates on the same edge as fail_vec, not one cycle later.
- en changes take effect at the sampling edge; no pipelining of inputs.
- Samples taken while !armed count toward nothing.

## Test plan
- Single channel: N_CH=4, HOLD=3, ARM_DELAY=0, FATAL=0; expr[1] high for 2 cycles, low, then high for 3 cycles.
  - Expected: only the second burst fires; fail_vec=4'b0010; fail_count=1; first_id=1; first_ts = ts of the 3rd high edge.
  - A single "ch=1" log line is printed.
- Arming: ARM_DELAY=5; expr[0] held high from reset release.
  - Expected: armed rises after edge 5; fire at the HOLD-th armed sample; first_ts=5+HOLD-1.
- Simultaneous fire: expr[3] and expr[2] rise together, HOLD=1.
  - Expected: first_id=2; fail_count=2; fail_vec=4'b1100; two log lines.
- clr collision: clr asserted on the same edge that ch0 fires, with prior fail_count=7.
  - Expected: fail_count=1; fail_vec=4'b0001; first_id=0; first_valid=1.
- Saturation and reset: CNT_W=2; force 5 separate firing episodes, then mid-episode assert rst for 1 cycle.
  - Expected: fail_count saturates at 3; after rst all outputs are 0 and the episode is not counted.
- FATAL=1: ch0 and ch1 fire on the same edge.
  - Expected: both log lines are printed, then simulation ends at that edge.
